// File: rtl/pixel_seq_check.sv
// Pixel sequence checker: tracks the expected (x,y) raster position of incoming words and flags errors.
// Latency: one cycle; every output reflects the word sampled on the previous clock edge.
// Backpressure: none; a word is accepted every cycle recv_en is high.
module pixel_seq_check #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int H_HALF   = 640,
  parameter int X_OFFSET = 4096
) (
  input  logic        clk125,
  input  logic        sys_rst_n,
  input  logic [28:0] datain,
  input  logic        recv_en,
  input  logic        packet_en,
  input  logic        clr,
  output logic        locked,
  output logic [11:0] exp_x,
  output logic [11:0] exp_y,
  output logic        err_half,
  output logic        err_x,
  output logic        err_y,
  output logic        err_pulse,
  output logic [15:0] err_cnt,
  output logic [15:0] frame_cnt,
  output logic [15:0] pkt_cnt
);

  localparam logic [0:0]  HUNT   = 1'b0;
  localparam logic [0:0]  LOCK   = 1'b1;
  localparam logic [11:0] X_LAST = 12'(H_ACTIVE - 1);
  localparam logic [11:0] Y_LAST = 12'(V_ACTIVE - 1);
  localparam logic [11:0] X_MID  = 12'(H_HALF);
  localparam logic [15:0] X_BIAS = 16'(X_OFFSET);

  logic [0:0]  state_q, state_d;
  logic [11:0] exp_x_q, exp_x_d, exp_y_q, exp_y_d;
  logic        err_half_q, err_half_d, err_x_q, err_x_d, err_y_q, err_y_d;
  logic        err_pulse_q, err_pulse_d;
  logic [15:0] err_cnt_q, err_cnt_d, frame_cnt_q, frame_cnt_d, pkt_cnt_q, pkt_cnt_d;
  logic        pkt_en_q, pkt_en_d;

  // Word decode; the x field carries a bias that is stripped here, bit 28 is unused.
  logic [15:0] x_diff;
  logic [11:0] org_x, org_y;
  logic        unused_bits;
  assign x_diff      = datain[15:0] - X_BIAS;
  assign org_x       = x_diff[11:0];
  assign org_y       = {1'b0, datain[26:16]};
  assign unused_bits = ^{datain[28], x_diff[15:12]};

  logic half_bad, x_bad, y_bad, any_bad;
  assign half_bad = datain[27] ? (org_x < X_MID) : (org_x >= X_MID);
  assign x_bad    = (org_x != exp_x_q);
  assign y_bad    = (org_y != exp_y_q);
  assign any_bad  = half_bad | x_bad | y_bad;

  // Next expectation derived from the received coordinate so a dropped word costs one error.
  logic [11:0] nx, ny;
  always_comb begin
    nx = org_x + 12'd1;
    ny = org_y;
    if (org_y > Y_LAST) begin
      nx = 12'd0;
      ny = 12'd0;
    end else if ((org_x >= X_LAST) || (org_x > X_LAST)) begin
      nx = 12'd0;
      ny = (org_y == Y_LAST) ? 12'd0 : org_y + 12'd1;
    end
  end

  // Next-state logic: clr has priority over a word arriving in the same cycle.
  always_comb begin
    state_d     = state_q;
    exp_x_d     = exp_x_q;
    exp_y_d     = exp_y_q;
    err_half_d  = err_half_q;
    err_x_d     = err_x_q;
    err_y_d     = err_y_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    frame_cnt_d = frame_cnt_q;
    pkt_cnt_d   = (pkt_en_q && !packet_en) ? pkt_cnt_q + 16'd1 : pkt_cnt_q;
    pkt_en_d    = packet_en;
    if (clr) begin
      state_d    = HUNT;
      exp_x_d    = 12'd0;
      exp_y_d    = 12'd0;
      err_half_d = 1'b0;
      err_x_d    = 1'b0;
      err_y_d    = 1'b0;
      err_cnt_d  = 16'd0;
      frame_cnt_d = 16'd0;
      pkt_cnt_d  = 16'd0;
    end else if (recv_en) begin
      if (state_q == HUNT) begin
        if (org_x == 12'd0 && org_y == 12'd0) begin
          state_d = LOCK;
          exp_x_d = 12'd1;
          exp_y_d = 12'd0;
        end
      end else begin
        exp_x_d = nx;
        exp_y_d = ny;
        if (any_bad) begin
          err_half_d  = err_half_q | half_bad;
          err_x_d     = err_x_q | x_bad;
          err_y_d     = err_y_q | y_bad;
          err_pulse_d = 1'b1;
          if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        end else if (org_x == X_LAST && org_y == Y_LAST) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk125) begin
    if (!sys_rst_n) begin
      state_q     <= HUNT;
      exp_x_q     <= 12'd0;
      exp_y_q     <= 12'd0;
      err_half_q  <= 1'b0;
      err_x_q     <= 1'b0;
      err_y_q     <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= 16'd0;
      frame_cnt_q <= 16'd0;
      pkt_cnt_q   <= 16'd0;
      pkt_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_x_q     <= exp_x_d;
      exp_y_q     <= exp_y_d;
      err_half_q  <= err_half_d;
      err_x_q     <= err_x_d;
      err_y_q     <= err_y_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
      pkt_en_q    <= pkt_en_d;
    end
  end

  assign locked    = (state_q == LOCK);
  assign exp_x     = exp_x_q;
  assign exp_y     = exp_y_q;
  assign err_half  = err_half_q;
  assign err_x     = err_x_q;
  assign err_y     = err_y_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;
  assign frame_cnt = frame_cnt_q;
  assign pkt_cnt   = pkt_cnt_q;

endmodule
